// File: rtl/mem_pkg.sv
// Shared opcodes, size codes and FSM encoding
// for the memory-access pipeline stage.
package mem_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  function automatic logic writes_rd(
    input logic [6:0] op
  );
    return op inside {OP_REG, OP_IMM, OP_LUI,
                      OP_AUIPC, OP_JAL, OP_JALR};
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return (size == SZ_H && off[0]) ||
           (size == SZ_W && off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus: req/gnt request phase,
// rvalid response phase.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and
// lane extraction plus extension for loads.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  lb;
  logic [15:0] lh;

  always_comb begin
    be    = 4'b1111;
    wdata = sdata;
    ldata = rdata;
    lb    = rdata[{off, 3'b000} +: 8];
    lh    = off[1] ? rdata[31:16]
                   : rdata[15:0];
    unique case (1'b1)
      (size == SZ_B): begin
        be    = 4'b0001 << off;
        wdata = {4{sdata[7:0]}};
        ldata = uns ? {24'b0, lb}
                    : {{24{lb[7]}}, lb};
      end
      (size == SZ_H): begin
        be    = 4'b0011 << off;
        wdata = {2{sdata[15:0]}};
        ldata = uns ? {16'b0, lh}
                    : {{16{lh[15]}}, lh};
      end
      default: begin
        be    = 4'b1111;
        wdata = sdata;
        ldata = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: bus loads/stores with
// timeout, single-cycle pass-through otherwise.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 10
) (
  input  logic        clk,
  input  logic        rstl,
  input  logic [10:0] opcode_exe_2_mem_i,
  input  logic [4:0]  rd_exe_2_mem_i,
  input  logic [31:0] rd_data_exe_2_mem_i,
  input  logic [31:0] mem_data_i,
  input  logic        load_valid_i,
  input  logic        store_valid_i,
  input  logic [31:0] current_pc_mem_i,
  output logic        stall_mem_o,
  mem_stage_if.master dmem,
  output logic        wb_valid_o,
  output logic [4:0]  rd_mem_2_wb_o,
  output logic [31:0] rd_data_mem_2_wb_o,
  output logic [31:0] current_pc_mem_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       f3_q;
  logic [31:0]      addr_q, sdata_q;
  logic             ld_q;
  logic             mem_in, mis, tmo;
  logic             ld_done, req;
  logic [3:0]       be;
  logic [31:0]      wdata, ldata;
  logic             unused;

  assign unused  = opcode_exe_2_mem_i[10];
  assign mem_in  = load_valid_i | store_valid_i;
  assign mis     = misaligned(
                     opcode_exe_2_mem_i[8:7],
                     rd_data_exe_2_mem_i[1:0]);
  assign cnt_nxt = cnt + 1'b1;

  mem_lane_align u_align (
    .off   (addr_q[1:0]),
    .size  (f3_q[1:0]),
    .uns   (f3_q[2]),
    .sdata (sdata_q),
    .rdata (dmem.rdata),
    .be    (be),
    .wdata (wdata),
    .ldata (ldata)
  );

  always_comb begin
    state_n = state;
    tmo     = 1'b0;
    ld_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_in && !mis) state_n = REQ;
      end
      REQ: begin
        if (dmem.gnt) begin
          state_n = ld_q ? RESP : IDLE;
        end else if (cnt_nxt == CNT_W'(TIMEOUT_CYC)) begin
          state_n = IDLE;
          tmo     = 1'b1;
        end
      end
      RESP: begin
        if (dmem.rvalid) begin
          state_n = IDLE;
          ld_done = 1'b1;
        end else if (cnt_nxt == CNT_W'(TIMEOUT_CYC)) begin
          state_n = IDLE;
          tmo     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus outputs read as zero outside REQ
  assign req         = (state == REQ);
  assign stall_mem_o = (state != IDLE);
  assign dmem.req    = req;
  assign dmem.we     = req & ~ld_q;
  assign dmem.addr   = req ? {addr_q[31:2], 2'b00}
                           : '0;
  assign dmem.be     = req ? be : '0;
  assign dmem.wdata  = req ? wdata : '0;

  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      state              <= IDLE;
      cnt                <= '0;
      f3_q               <= '0;
      addr_q             <= '0;
      sdata_q            <= '0;
      ld_q               <= 1'b0;
      wb_valid_o         <= 1'b0;
      rd_mem_2_wb_o      <= '0;
      rd_data_mem_2_wb_o <= '0;
      current_pc_mem_o   <= '0;
      misalign_o         <= 1'b0;
      bus_err_o          <= 1'b0;
    end else begin
      state      <= state_n;
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= tmo;
      cnt        <= (state == IDLE) ? '0 : cnt_nxt;
      if (state == IDLE) begin
        rd_mem_2_wb_o    <= rd_exe_2_mem_i;
        current_pc_mem_o <= current_pc_mem_i;
        if (mem_in) begin
          f3_q       <= opcode_exe_2_mem_i[9:7];
          addr_q     <= rd_data_exe_2_mem_i;
          sdata_q    <= mem_data_i;
          ld_q       <= load_valid_i;
          misalign_o <= mis;
        end else begin
          rd_data_mem_2_wb_o <= rd_data_exe_2_mem_i;
          wb_valid_o <= writes_rd(opcode_exe_2_mem_i[6:0])
                        && rd_exe_2_mem_i != '0;
        end
      end
      if (ld_done) begin
        rd_data_mem_2_wb_o <= ldata;
        wb_valid_o         <= rd_mem_2_wb_o != '0;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and writeback. It consumes the execute stage's registered outputs: opcode, rd, result/address, store data, load_valid and store_valid.
- Loads and stores run over a req/gnt/rvalid data-memory bus with byte-lane alignment, strobes, sign/zero extension, a misalignment check and a bus timeout.
- Non-memory results pass to writeback with one cycle of latency.
- While a bus transaction is open, the stage stalls upstream.

Parameters:
TIMEOUT_CYC, 255, max cycles spent in REQ+RESP before abort (1..1023)
CNT_W, 10, timeout counter width

Ports:
clk  in  1  clock
rstl  in  1  reset, asynchronous, active-low
opcode_exe_2_mem_i  in  11  {funct7[5], funct3, opcode[6:0]}; 0 = bubble
rd_exe_2_mem_i  in  5  destination register
rd_data_exe_2_mem_i  in  32  ALU result, or effective address for load/store
mem_data_i  in  32  store data, right-justified (zero-extended SB/SH data)
load_valid_i  in  1  load present
store_valid_i  in  1  store present
current_pc_mem_i  in  32  instruction PC
stall_mem_o  out  1  upstream must hold its outputs
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  32  word address, bits[1:0] = 0
dmem_be_o  out  4  byte strobes
dmem_wdata_o  out  32  lane-shifted write data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  32  read word
wb_valid_o  out  1  register-file write enable, 1-cycle pulse
rd_mem_2_wb_o  out  5  destination register
rd_data_mem_2_wb_o  out  32  writeback data
current_pc_mem_o  out  32  PC of the retiring instruction
misalign_o  out  1  1-cycle pulse, misaligned access suppressed
bus_err_o  out  1  1-cycle pulse, bus timeout

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0. Reset during REQ/RESP aborts the access with no writeback, and a later rvalid is ignored.
- FSM states: IDLE, REQ, RESP. stall_mem_o = (state != IDLE), decoded from the state register.
- IDLE, no load/store:
  - Register rd, data and PC to the outputs.
  - wb_valid_o = writes_rd && rd != 0. writes_rd means opcode[6:0] is one of 0110011, 0010011, 0110111, 0010111, 1101111, 1100111.
  - Branches, stores and bubbles give wb_valid_o = 0.
- IDLE, load_valid_i or store_valid_i:
  - Latch opcode, rd, address, data and PC.
  - Misalignment check: funct3[1:0] = 01 requires addr[0] = 0; funct3[1:0] = 10 requires addr[1:0] = 0.
  - Misaligned: pulse misalign_o the next cycle, wb_valid_o = 0, no request, stay in IDLE.
  - Aligned: go to REQ; dmem_req_o = 1 from the next cycle; counter cleared.
- REQ:
  - req, we, addr, be and wdata are held stable until gnt is sampled 1.
  - On gnt: a store finishes (go to IDLE, wb_valid_o = 0); a load goes to RESP.
- RESP: on rvalid (never earlier than the cycle after gnt), go to IDLE.
  - Load data is extracted using the latched addr[1:0]: LB/LBU use byte offset addr[1:0]; LH/LHU use half addr[1]; LW uses the full word.
  - Sign-extend for funct3[2] = 0, zero-extend for funct3[2] = 1.
  - wb_valid_o = (rd != 0); writeback data is registered.
- Store lanes:
  - SB: be = 0001 << off; wdata = {4{byte}}.
  - SH: be = 0011 << off; wdata = {2{half}}.
  - SW: be = 1111.
- Timeout: the counter increments each cycle in REQ/RESP. When it reaches TIMEOUT_CYC: drop req, pulse bus_err_o, no writeback, go to IDLE.
- Upstream hold: inputs stay stable while stall_mem_o = 1. The instruction presented during the completion cycle is consumed in the following IDLE cycle.
- Timeout and gnt/rvalid in the same cycle: gnt/rvalid wins.
- Throughput: 1 instruction/cycle for non-memory ops. Minimum store = 2 cycles, minimum load = 3 cycles.

Decomposition:
- Package mem_pkg holds:
  - opcode[6:0] constants: LOAD 0000011, STORE 0100011, BRANCH 1100011 and the writes_rd set.
  - funct3 size codes: B 00, H 01, W 10; bit 2 = unsigned.
  - FSM state enum.
- Sub-module mem_lane_align (combinational):
  - store path: addr[1:0], size, data → be, wdata.
  - load path: addr[1:0], size, unsigned, rdata → extended value.

Test Plan:
1. ADD 0_000_0110011, rd=5, data 0x00001234 → next cycle wb_valid_o=1, rd_mem_2_wb_o=5, rd_data=0x00001234, dmem_req_o=0, stall_mem_o=0.
2. SB, addr 0x00001003, data 0xAB, gnt held low 2 cycles → dmem_addr=0x00001000, be=1000, wdata=0xABABABAB, req and stall high 3 cycles then low, wb_valid_o=0.
3. LB at 0x00002002, rdata 0x00800000 → wb data 0xFFFFFF80; LBU same → 0x00000080; LH at 0x00002002, rdata 0x80000000 → 0xFFFF8000.
4. LW at 0x00002002 → misalign_o pulse, no dmem_req_o, wb_valid_o=0; next ADD retires the following cycle.
5. TIMEOUT_CYC=4, gnt stuck low → bus_err_o pulses after 4 req cycles, req/stall drop, no writeback.
6. LW rd=0 completes on the bus with wb_valid_o=0. Separately, rstl low during RESP → all outputs 0; a late rvalid causes no writeback.
